// File: rtl/rsa_pkg.sv
// Shared definitions for the systolic-array result path: default tile geometry
// and the output-collector FSM state encoding.
package rsa_pkg;

    localparam int RSA_X       = 3;
    localparam int RSA_Y       = 3;
    localparam int RSA_OUT_LEN = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_READ    = 2'd2
    } rsa_state_e;

endpackage

// File: rtl/rsa_res_ram.sv
// Tile result store: simple dual-port RAM, synchronous write, registered read.
// Read data appears one cycle after rd_en and holds while rd_en is low.
module rsa_res_ram #(
    parameter int DEPTH = 9,
    parameter int AW    = 4,
    parameter int W     = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rd_data_q;
    logic [W-1:0] rd_data_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    // Only the output register is reset, so the readout port is clean during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/rsa_out_collector.sv
// Captures one X*Y result tile from the array, then streams it out (column-major when RSA_COLLECT_TRANSPOSE_EN).
// Latency: res_val rises one cycle after the tile completes; one word per cycle thereafter.
// Backpressure: res_rdy stalls readout (word held); in_val has none, input during readout is dropped and flagged.
module rsa_out_collector
    import rsa_pkg::*;
#(
    parameter int X       = RSA_X,
    parameter int Y       = RSA_Y,
    parameter int OUT_LEN = RSA_OUT_LEN
) (
    input  logic             clk,
    input  logic             sys_rst_n,
    input  logic             in_val,
    input  logic [OUT_LEN:1] in_data,
    output logic             res_val,
    input  logic             res_rdy,
    output logic [OUT_LEN:1] res_data,
    output logic             res_last,
    output logic             tile_done,
    output logic             ovf_err
);

    localparam int DEPTH = X * Y;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AW1   = AW + 1;

    logic [1:0]       rst_sync_q;
    logic [1:0]       rst_sync_d;
    logic             rst_n;

    rsa_state_e       state_q,     state_d;
    logic [CNT_W-1:0] wr_cnt_q,    wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q,    rd_cnt_d;
    logic [AW-1:0]    rd_ptr_q,    rd_ptr_d;
    logic             res_val_q,   res_val_d;
    logic             res_last_q,  res_last_d;
    logic             tile_done_q, tile_done_d;
    logic             ovf_err_q,   ovf_err_d;

    logic             wr_en;
    logic             rd_en;
    logic [AW-1:0]    rd_ptr_nxt;

    // Assert asynchronously, release on the clock.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_n = rst_sync_q[1];

`ifdef RSA_COLLECT_TRANSPOSE_EN
    // Walk down a column (stride Y); on falling off the end, start the next column.
    logic [AW1-1:0] ptr_step;
    always_comb begin
        ptr_step   = {1'b0, rd_ptr_q} + AW1'(Y);
        rd_ptr_nxt = rd_ptr_q;
        if (ptr_step >= AW1'(DEPTH)) begin
            rd_ptr_nxt = AW'(ptr_step - AW1'(DEPTH) + AW1'(1));
        end else begin
            rd_ptr_nxt = AW'(ptr_step);
        end
    end
`else
    always_comb begin
        rd_ptr_nxt = rd_ptr_q + AW'(1);
    end
`endif

    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        rd_ptr_d    = rd_ptr_q;
        res_val_d   = res_val_q;
        res_last_d  = res_last_q;
        tile_done_d = 1'b0;
        ovf_err_d   = ovf_err_q;
        wr_en       = 1'b0;
        rd_en       = 1'b0;

        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                if (in_val) begin
                    wr_en    = 1'b1;
                    wr_cnt_d = wr_cnt_q + CNT_W'(1);
                    if (wr_cnt_q == CNT_W'(DEPTH - 1)) begin
                        state_d     = ST_READ;
                        tile_done_d = 1'b1;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end
            end
            ST_READ: begin
                if (in_val) begin
                    ovf_err_d = 1'b1;
                end
                if (!res_val_q) begin
                    rd_en      = 1'b1;
                    rd_cnt_d   = CNT_W'(1);
                    rd_ptr_d   = rd_ptr_nxt;
                    res_val_d  = 1'b1;
                    res_last_d = (DEPTH == 1);
                end else if (res_rdy) begin
                    if (res_last_q) begin
                        state_d    = ST_IDLE;
                        res_val_d  = 1'b0;
                        res_last_d = 1'b0;
                        rd_cnt_d   = '0;
                        rd_ptr_d   = '0;
                        wr_cnt_d   = '0;
                    end else begin
                        // Prefetch on handshake keeps the stream at one word per cycle.
                        rd_en      = 1'b1;
                        rd_cnt_d   = rd_cnt_q + CNT_W'(1);
                        rd_ptr_d   = rd_ptr_nxt;
                        res_last_d = (rd_cnt_q == CNT_W'(DEPTH - 1));
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            rd_ptr_q    <= '0;
            res_val_q   <= 1'b0;
            res_last_q  <= 1'b0;
            tile_done_q <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            res_val_q   <= res_val_d;
            res_last_q  <= res_last_d;
            tile_done_q <= tile_done_d;
            ovf_err_q   <= ovf_err_d;
        end
    end

    rsa_res_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (OUT_LEN)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_cnt_q[AW-1:0]),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_q),
        .rd_data (res_data)
    );

    assign res_val   = res_val_q;
    assign res_last  = res_last_q;
    assign tile_done = tile_done_q;
    assign ovf_err   = ovf_err_q;

endmodule
